alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage that sits directly upstream of the ALU result/writeback path. It wraps the combinational ALU functions (ADD, COMP, AND, XOR, NOT) and adds an iterative shifter.
- Latches operands on a start strobe and produces a registered 32-bit result, carry/zero/sign flags and a one-cycle done pulse.
- Shifts execute one bit per clock, so the stage is multi-cycle and reports busy to the controller.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; shift amount is B[SHAMT_W-1:0].

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin operation; sampled only while busy=0.
- op  input  3  000 ADD, 001 COMP (two's complement of A), 010 AND, 011 XOR, 100 NOT (~A), 101 SHLL, 110 SHRL, 111 SHRA.
- A  input  DATA_W  operand A (shift source).
- B  input  DATA_W  operand B; low SHAMT_W bits are the shift amount for shifts.
- result  output  DATA_W  registered result; held until the next done.
- carry  output  1  carry flag.
- zero  output  1  result==0.
- sign  output  1  result[DATA_W-1].
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.

Behaviour:
- Reset: on any rising edge with rst=1, result=0, carry=0, zero=0, sign=0, busy=0, done=0, state=IDLE. Internal accumulator and counter are cleared. Reset aborts an in-progress shift with no done pulse. rst has priority over start.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge k:
  - Non-shift op, or shift with amount n=0: result, flags and done=1 are all updated at edge k. Latency 1; busy stays 0.
  - Shift with n>0: A is latched into the accumulator, cnt=n, busy=1, state goes to SHIFT. result and flags are unchanged.
- SHIFT, each edge:
  - Shift the accumulator by one bit. SHLL inserts 0 at the LSB; SHRL inserts 0 at the MSB; SHRA replicates the MSB. Then decrement cnt.
  - On the edge where cnt goes 1->0: result=shifted value, flags updated, done=1, busy=0, state=IDLE.
  - Total: done asserted after edge k+n; busy high for exactly n cycles.
- done is 0 in every cycle not listed above. Flags update only together with a done pulse.
- start while busy=1 is ignored: no queuing, and the operands are not re-latched. start is also ignored in the same cycle that done is asserted from SHIFT, because busy is still 1 at that edge.
- A, B and op may change freely after the start edge; the operation uses the latched values.
- Arithmetic:
  - ADD: {carry,result} = A+B, evaluated at DATA_W+1 bits with wrap-around.
  - COMP: result = ~A+1; carry=1 only when A==0.
  - AND, XOR, NOT: carry=0.
  - Shifts: carry = last bit shifted out. For n=0, carry=0 and result=A.
  - zero and sign are always derived from the new result.
- Back-to-back non-shift ops with start held high produce done on consecutive cycles.

Test Plan:
- Reset mid-shift: start SHRL, A=32'hFFFF_FFFF, B=10; assert rst at cycle 3 -> no done pulse; busy=0, result=0 and all flags 0 on the next edge; idle afterwards.
- ADD overflow: A=32'hFFFF_FFFF, B=1, start for 1 cycle -> done after the first edge; result=0, carry=1, zero=1, sign=0, busy never 1.
- NOT/COMP: NOT with A=10 -> result=32'hFFFF_FFF5, sign=1, carry=0. COMP with A=0 -> result=0, carry=1, zero=1. COMP with A=33 -> result=32'hFFFF_FFDF, carry=0.
- SHRA timing: A=32'h8000_0000, B=4 -> busy high for 4 cycles; done after the 4th edge following start; result=32'hF800_0000, carry=0, sign=1. Same with B=0 -> done after 1 edge, result=A.
- SHLL carry: A=32'hC000_0001, B=1 -> result=32'h8000_0002, carry=1. Then SHRL A=33, B=31 -> result=0, zero=1, carry=0, busy high for 31 cycles.
- start ignored while busy: start SHLL A=1, B=5, then pulse start with ADD during busy -> a single done pulse after 5 edges with result=32; the ADD is never executed. Back-to-back AND/XOR with start held high -> done on 2 consecutive cycles.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute stage with single-cycle ALU ops and a bit-serial shifter
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              sign,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_COMP = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_XOR  = 3'b011;
    localparam logic [2:0] c_OP_NOT  = 3'b100;
    localparam logic [2:0] c_OP_SHLL = 3'b101;
    localparam logic [2:0] c_OP_SHRL = 3'b110;
    localparam logic [2:0] c_OP_SHRA = 3'b111;

    localparam logic [DATA_W-1:0]  c_ONE     = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [SHAMT_W-1:0]  r_cnt;
    logic [2:0]          r_op;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_res;
    logic                w_carry;
    logic [SHAMT_W-1:0]  w_shamt;
    logic                w_is_shift;
    logic [DATA_W-1:0]   w_step;
    logic                w_shout;

    assign w_sum      = {1'b0, A} + {1'b0, B};
    assign w_shamt    = B[SHAMT_W-1:0];
    assign w_is_shift = (op == c_OP_SHLL) || (op == c_OP_SHRL) || (op == c_OP_SHRA);

    // Single-cycle result; a zero-length shift falls through to result=A, carry=0
    always_comb begin
        w_res   = A;
        w_carry = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            c_OP_COMP: begin
                w_res   = ~A + c_ONE;
                w_carry = (A == '0);
            end
            c_OP_AND: w_res = A & B;
            c_OP_XOR: w_res = A ^ B;
            c_OP_NOT: w_res = ~A;
            default:  w_res = A;
        endcase
    end

    // One-bit shift step of the accumulator and the bit it pushes out
    always_comb begin
        w_step  = r_acc;
        w_shout = 1'b0;
        case (r_op)
            c_OP_SHLL: begin
                w_step  = {r_acc[DATA_W-2:0], 1'b0};
                w_shout = r_acc[DATA_W-1];
            end
            c_OP_SHRL: begin
                w_step  = {1'b0, r_acc[DATA_W-1:1]};
                w_shout = r_acc[0];
            end
            c_OP_SHRA: begin
                w_step  = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
                w_shout = r_acc[0];
            end
            default: begin
                w_step  = r_acc;
                w_shout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            sign    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_acc   <= A;
                            r_cnt   <= w_shamt;
                            r_op    <= op;
                            busy    <= 1'b1;
                            r_state <= S_SHIFT;
                        end else begin
                            result <= w_res;
                            carry  <= w_carry;
                            zero   <= (w_res == '0);
                            sign   <= w_res[DATA_W-1];
                            done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    // start is deliberately ignored here, including on the final step
                    if (r_cnt == c_CNT_ONE) begin
                        result  <= w_step;
                        carry   <= w_shout;
                        zero    <= (w_step == '0);
                        sign    <= w_step[DATA_W-1];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Scoreboard bench for alu_exec_unit (results, flags, latency, busy)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [DW-1:0] result;
    logic          carry;
    logic          zero;
    logic          sign;
    logic          busy;
    logic          done;

    alu_exec_unit #(.DATA_W(DW), .SHAMT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .result (result),
        .carry  (carry),
        .zero   (zero),
        .sign   (sign),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic          c;
        logic          z;
        logic          s;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] o, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input int cyc_now);
        exp_t e;
        int   n;
        n     = int'(b[4:0]);
        e.c   = 1'b0;
        e.res = a;
        case (o)
            3'd0: {e.c, e.res} = {1'b0, a} + {1'b0, b};
            3'd1: begin e.res = -a; e.c = (a == 0); end
            3'd2: e.res = a & b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = ~a;
            3'd5: if (n != 0) begin e.res = a << n; e.c = a[DW-n]; end
            3'd6: if (n != 0) begin e.res = a >> n; e.c = a[n-1]; end
            default: if (n != 0) begin e.res = $unsigned($signed(a) >>> n); e.c = a[n-1]; end
        endcase
        e.z   = (e.res == 0);
        e.s   = e.res[DW-1];
        e.cyc = cyc_now + 1 + ((o >= 3'd5) ? n : 0);
        return e;
    endfunction

    // Retire scoreboard entries as done pulses appear
    always @(negedge clk) begin
        if (done === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done cyc=%0d result=%h, required no done pulse", cyc, result);
            end else begin
                mon_e = sb.pop_front();
                if ({result, carry, zero, sign} !== {mon_e.res, mon_e.c, mon_e.z, mon_e.s}) begin
                    miscompares++;
                    $display("FAIL done_result got res=%h c=%b z=%b s=%b, required res=%h c=%b z=%b s=%b",
                             result, carry, zero, sign, mon_e.res, mon_e.c, mon_e.z, mon_e.s);
                end
                vectors++;
                if (cyc !== mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL done_latency got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    // Issue one op at a negedge, release start, and count busy cycles over window
    task automatic drive_op(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input int window, output int busy_cycles);
        start = 1'b1; op = o; A = a; B = b;
        sb.push_back(model(o, a, b, cyc));
        busy_cycles = 0;
        for (int j = 1; j <= window; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h, required 0", result); end
        vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry got %b, required 0", carry); end
        vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b, required 0", zero); end
        vectors++; if (sign !== 1'b0) begin miscompares++; $display("FAIL reset_sign got %b, required 0", sign); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b, required 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b, required 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_overflow;
        int bc;
        drive_op(3'd0, 32'hFFFF_FFFF, 32'h1, 3, bc);
        vectors++; if (bc !== 0) begin miscompares++; $display("FAIL add_busy got %0d, required 0", bc); end
    endtask

    task automatic test_not_comp;
        int bc;
        drive_op(3'd4, 32'd10, 32'h0, 2, bc);
        drive_op(3'd1, 32'd0, 32'h0, 2, bc);
        drive_op(3'd1, 32'd33, 32'h0, 2, bc);
        vectors++; if (bc !== 0) begin miscompares++; $display("FAIL comp_busy got %0d, required 0", bc); end
    endtask

    task automatic test_shra;
        int bc;
        drive_op(3'd7, 32'h8000_0000, 32'd4, 6, bc);
        vectors++; if (bc !== 4) begin miscompares++; $display("FAIL shra4_busy got %0d, required 4", bc); end
        drive_op(3'd7, 32'h8000_0000, 32'd0, 2, bc);
        vectors++; if (bc !== 0) begin miscompares++; $display("FAIL shra0_busy got %0d, required 0", bc); end
    endtask

    task automatic test_shll_shrl;
        int bc;
        drive_op(3'd5, 32'hC000_0001, 32'd1, 3, bc);
        vectors++; if (bc !== 1) begin miscompares++; $display("FAIL shll1_busy got %0d, required 1", bc); end
        drive_op(3'd6, 32'd33, 32'd31, 33, bc);
        vectors++; if (bc !== 31) begin miscompares++; $display("FAIL shrl31_busy got %0d, required 31", bc); end
    endtask

    task automatic test_start_ignored;
        int bc = 0;
        start = 1'b1; op = 3'd5; A = 32'd1; B = 32'd5;
        sb.push_back(model(3'd5, 32'd1, 32'd5, cyc));
        // start held high with an ADD across the whole shift, including the done edge
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) begin op = 3'd0; A = 32'd7; B = 32'd8; end
            if (j == 6) start = 1'b0;
            if (busy === 1'b1) bc++;
        end
        vectors++; if (bc !== 5) begin miscompares++; $display("FAIL ignored_busy got %0d, required 5", bc); end
        vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL ignored_pending got %0d, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        int bc = 0;
        start = 1'b1; op = 3'd2; A = 32'hF0F0_F0F0; B = 32'hFF00_FF00;
        sb.push_back(model(3'd2, A, B, cyc));
        @(negedge clk);
        if (busy === 1'b1) bc++;
        op = 3'd3; A = 32'h1234_5678; B = 32'h0000_FFFF;
        sb.push_back(model(3'd3, A, B, cyc));
        @(negedge clk);
        if (busy === 1'b1) bc++;
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bc !== 0) begin miscompares++; $display("FAIL b2b_busy got %0d, required 0", bc); end
        vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL b2b_pending got %0d, required 0", sb.size()); end
    endtask

    task automatic test_mixed;
        int bc;
        logic [2:0]    o;
        logic [DW-1:0] a, b;
        int            lat;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (o >= 3'd5) b[4:0] = 5'($urandom_range(0, 12));
            lat = (o >= 3'd5) ? int'(b[4:0]) : 0;
            drive_op(o, a, b, lat + 2, bc);
            vectors++;
            if (bc !== lat) begin miscompares++; $display("FAIL mixed_busy op=%0d got %0d, required %0d", o, bc, lat); end
        end
    endtask

    task automatic test_reset_mid_shift;
        int bc;
        drive_op(3'd3, 32'hA5A5_0000, 32'h0000_5A5A, 2, bc);
        start = 1'b1; op = 3'd6; A = 32'hFFFF_FFFF; B = 32'd10;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midshift_busy got %b, required 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({result, carry, zero, sign, busy, done} !== {32'h0, 5'b0}) begin
            miscompares++;
            $display("FAIL midshift_reset got res=%h c=%b z=%b s=%b busy=%b done=%b, required all 0",
                     result, carry, zero, sign, busy, done);
        end
        bc = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy !== 1'b0) bc++;
        end
        vectors++; if (bc !== 0) begin miscompares++; $display("FAIL midshift_idle got %0d busy cycles, required 0", bc); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_not_comp();
        test_shra();
        test_shll_shrl();
        test_start_ignored();
        test_back_to_back();
        test_mixed();
        test_reset_mid_shift();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL final_pending got %0d outstanding results, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
